// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared CPU definitions: opcodes, NOP word, fetch state encoding
package cpu_defs;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] DEF_NOP_INST = 16'h0000;
    localparam logic [3:0]  DEF_HLT_OPC  = 4'hF;
    localparam logic [3:0]  OPC_BEQ      = 4'hC;
    localparam logic [3:0]  OPC_BNE      = 4'hD;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Instructions are halfword aligned, so bit 0 of any jump target is dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory fetch handshake between fetch stage and memory
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_valid;

    modport master (output imem_addr, output imem_rd, input imem_data, input imem_valid);
    modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_valid);
endinterface

// File: rtl/fetch_stage_pipe_reg.sv
// rtl/fetch_stage_pipe_reg.sv - pipeline register with async reset value, enable and sync clear
module pipe_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = RST_VAL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RST_VAL;
        end else if (clr_i) begin
            q_o <= CLR_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage and IF/ID register of the 16-bit pipelined CPU
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] NOP_INST = DEF_NOP_INST,
    parameter logic [3:0]  HLT_OPC  = DEF_HLT_OPC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 if_flush,
    input  logic [15:0]          br_target,
    fetch_stage_if.master        imem,
    output logic [15:0]          if_id_inst,
    output logic [15:0]          if_id_pc_plus2,
    output logic                 if_id_valid,
    output logic                 halt
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         pc_en;
    logic         ifid_load, ifid_clr;
    logic         redir_pend_q, redir_pend_d;
    logic [15:0]  redir_tgt_q, redir_tgt_d;
    logic [15:0]  pc_plus2;
    logic         is_hlt;

    assign pc_plus2 = pc_q + 16'd2;
    assign is_hlt   = (imem.imem_data[15:12] == HLT_OPC);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_en        = 1'b0;
        ifid_load    = 1'b0;
        ifid_clr     = 1'b0;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        if (if_flush) begin
            ifid_clr = 1'b1;
            if (imem.imem_valid || state_q != ST_WAIT) begin
                pc_d         = align_pc(br_target);
                pc_en        = 1'b1;
                state_d      = ST_FETCH;
                redir_pend_d = 1'b0;
            end else begin
                // The memory still owes us a word for the old PC; redirect once it lands.
                redir_tgt_d  = align_pc(br_target);
                redir_pend_d = 1'b1;
            end
        end else if (!stall) begin
            if (state_q == ST_HALT) begin
                ifid_clr = 1'b1;
            end else if (!imem.imem_valid) begin
                ifid_clr = 1'b1;
                state_d  = ST_WAIT;
            end else if (redir_pend_q) begin
                ifid_clr     = 1'b1;
                pc_d         = redir_tgt_q;
                pc_en        = 1'b1;
                redir_pend_d = 1'b0;
                state_d      = ST_FETCH;
            end else if (is_hlt) begin
                ifid_load = 1'b1;
                state_d   = ST_HALT;
            end else begin
                ifid_load = 1'b1;
                pc_d      = pc_plus2;
                pc_en     = 1'b1;
                state_d   = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    pipe_reg #(.W(16), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst_n(rst_n), .en_i(pc_en), .clr_i(1'b0), .d_i(pc_d), .q_o(pc_q)
    );

    pipe_reg #(.W(16), .RST_VAL(NOP_INST)) u_ifid_inst (
        .clk(clk), .rst_n(rst_n), .en_i(ifid_load), .clr_i(ifid_clr),
        .d_i(imem.imem_data), .q_o(if_id_inst)
    );

    pipe_reg #(.W(16), .RST_VAL(16'h0000)) u_ifid_pc2 (
        .clk(clk), .rst_n(rst_n), .en_i(ifid_load), .clr_i(ifid_clr),
        .d_i(pc_plus2), .q_o(if_id_pc_plus2)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_ifid_valid (
        .clk(clk), .rst_n(rst_n), .en_i(ifid_load), .clr_i(ifid_clr),
        .d_i(1'b1), .q_o(if_id_valid)
    );

    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = (state_q != ST_HALT);
    assign halt           = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        if_flush = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] tb_data = 16'h0000;
    logic        tb_valid = 1'b0;
    logic [15:0] if_id_inst, if_id_pc_plus2;
    logic        if_id_valid, halt;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if imem ();
    assign imem.imem_data  = tb_data;
    assign imem.imem_valid = tb_valid;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_flush(if_flush), .br_target(br_target),
        .imem(imem), .if_id_inst(if_id_inst), .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid(if_id_valid), .halt(halt)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];

    // Reference model: architectural view of what fetch should be doing.
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_outstanding;
    logic [15:0] m_redirect [$];
    logic [15:0] m_inst, m_pc2;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 16'h0000; m_halted = 1'b0; m_outstanding = 1'b0;
        m_redirect.delete();
        m_inst = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_inst = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [15:0] b,
                              input logic v, input logic [15:0] d);
        if (f) begin
            model_bubble();
            if (v || !m_outstanding) begin
                m_pc = {b[15:1], 1'b0}; m_outstanding = 1'b0; m_halted = 1'b0;
                m_redirect.delete();
            end else begin
                m_redirect.delete();
                m_redirect.push_back({b[15:1], 1'b0});
            end
        end else if (s) begin
        end else if (m_halted) begin
            model_bubble();
        end else if (!v) begin
            model_bubble(); m_outstanding = 1'b1;
        end else if (m_redirect.size() != 0) begin
            model_bubble(); m_pc = m_redirect.pop_front(); m_outstanding = 1'b0;
        end else begin
            m_inst = d; m_pc2 = m_pc + 16'd2; m_valid = 1'b1; m_outstanding = 1'b0;
            if (d[15:12] == 4'hF) m_halted = 1'b1;
            else                  m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem.imem_addr, m_pc);
        chk("imem_rd", {15'd0, imem.imem_rd}, {15'd0, !m_halted});
        chk("halt", {15'd0, halt}, {15'd0, m_halted});
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        chk("if_id_inst", if_id_inst, m_inst);
        if (m_valid) chk("if_id_pc_plus2", if_id_pc_plus2, m_pc2);
    endtask

    task automatic cyc(input logic s, input logic f, input logic [15:0] b, input logic v);
        stall = s; if_flush = f; br_target = b;
        tb_valid = v && !m_halted;
        tb_data = mem[m_pc[15:1]];
        @(posedge clk);
        model_step(s, f, b, tb_valid, tb_data);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        mem[16'h0020 >> 1] = 16'hF000;

        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        rst_n = 1'b1;

        // Zero-wait straight-line code
        cyc(0, 0, 16'h0, 1); chk("t1_pc2_a", if_id_pc_plus2, 16'h0002);
        cyc(0, 0, 16'h0, 1); chk("t1_pc2_b", if_id_pc_plus2, 16'h0004);
        cyc(0, 0, 16'h0, 1); chk("t1_pc2_c", if_id_pc_plus2, 16'h0006);

        // Stall at 0x0010
        cyc(0, 1, 16'h0010, 1);
        cyc(1, 0, 16'h0, 1); chk("t2_addr_a", imem.imem_addr, 16'h0010);
        cyc(1, 0, 16'h0, 1); chk("t2_addr_b", imem.imem_addr, 16'h0010);
        cyc(0, 0, 16'h0, 1); chk("t2_resume", imem.imem_addr, 16'h0012);

        // Taken branch to 0x0040 (odd target bit dropped)
        cyc(0, 1, 16'h0041, 1);
        chk("t3_valid", {15'd0, if_id_valid}, 16'd0);
        chk("t3_addr", imem.imem_addr, 16'h0040);
        cyc(0, 0, 16'h0, 1); chk("t3_pc2", if_id_pc_plus2, 16'h0042);

        // Branch while a fetch is outstanding
        cyc(0, 0, 16'h0, 0);
        cyc(0, 1, 16'h0080, 0);
        cyc(0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 1);
        chk("t4_addr", imem.imem_addr, 16'h0080);
        chk("t4_drop", {15'd0, if_id_valid}, 16'd0);

        // HLT at 0x0020
        cyc(0, 1, 16'h0020, 1);
        cyc(0, 0, 16'h0, 1);
        chk("t5_halt", {15'd0, halt}, 16'd1);
        chk("t5_rd", {15'd0, imem.imem_rd}, 16'd0);
        chk("t5_inst", if_id_inst, 16'hF000);
        cyc(0, 0, 16'h0, 1); chk("t5_frozen", imem.imem_addr, 16'h0020);
        cyc(0, 1, 16'h0030, 0);
        chk("t5_unhalt", {15'd0, halt}, 16'd0);
        chk("t5_addr", imem.imem_addr, 16'h0030);

        // PC wrap and reset mid-WAIT
        cyc(0, 1, 16'hFFFE, 1);
        cyc(0, 0, 16'h0, 1);
        chk("t6_wrap", imem.imem_addr, 16'h0000);
        chk("t6_pc2", if_id_pc_plus2, 16'h0000);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_addr", imem.imem_addr, 16'h0000);
        chk("t6_rst_valid", {15'd0, if_id_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        cyc(0, 0, 16'h0, 1); chk("t6_first", if_id_pc_plus2, 16'h0002);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic s, f, v;
            logic [15:0] b;
            s = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 10);
            v = ($urandom_range(0, 99) < 70);
            b = 16'($urandom);
            if ($urandom_range(0, 99) < 5) mem[b[15:1]] = 16'hF123;
            cyc(s, f, b, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
